// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter with a one-entry hold buffer.
// Words arrive over a valid/ready handshake and leave on p one bit per clock,
// with queued words following each other back to back (no idle gap).
module piso_tx #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             in_ready,
  output logic             p,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             p_q, p_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             end_s;
  logic             load_hold_s;
  logic             load_in_s;
  logic             to_hold_s;
  logic [WIDTH-1:0] load_word_s;

  // Handshake, load decisions and next-state for shifter, counter and hold buffer.
  always_comb begin
    accept_s    = in_valid && !hold_full_q;
    end_s       = (state_q == SHIFT) && (cnt_q == LAST);
    // A full hold at end of word always wins; in_ready is low then anyway.
    load_hold_s = end_s && hold_full_q;
    load_in_s   = accept_s && ((state_q == IDLE) || end_s);
    to_hold_s   = accept_s && (state_q == SHIFT) && !end_s;
    load_word_s = load_hold_s ? hold_q : d;

    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    frame_d     = 1'b0;
    busy_d      = busy_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (load_hold_s || load_in_s) begin
      // Start a new word: its first bit appears on p right after this edge.
      state_d = SHIFT;
      shreg_d = load_word_s;
      cnt_d   = {CW{1'b0}};
      p_d     = MSB_FIRST ? load_word_s[WIDTH-1] : load_word_s[0];
      frame_d = 1'b1;
      busy_d  = 1'b1;
    end else if ((state_q == SHIFT) && !end_s) begin
      // Mid-word: move to the next bit of the current word.
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CW'(1);
      p_d     = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
      busy_d  = 1'b1;
    end else begin
      // Nothing to send: line rests at the idle level.
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
      p_d     = IDLE_LEVEL;
      busy_d  = 1'b0;
    end

    if (load_hold_s) begin
      hold_full_d = 1'b0;
    end else if (to_hold_s) begin
      hold_d      = d;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end

    done_d = busy_d && (cnt_d == LAST);
  end

  // State, data and output registers; reset aborts any word and empties hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= {WIDTH{1'b0}};
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      p_q         <= IDLE_LEVEL;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready = !hold_full_q;
  assign p        = p_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: table-driven backpressure vectors, hand-written
// corner sequences, and random traffic against a bit-queue reference model.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] d = '0;
  logic         in_ready, p, frame, busy, done;

  logic         v6 = 1'b0;
  logic [W-1:0] d6 = '0;
  logic         rdy6, p6, frame6, busy6, done6;

  logic [W-1:0] sic_q = '0;

  int n_pass  = 0;
  int n_total = 0;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d(d), .in_ready(in_ready),
    .p(p), .frame(frame), .busy(busy), .done(done)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .d(d6), .in_ready(rdy6),
    .p(p6), .frame(frame6), .busy(busy6), .done(done6)
  );

  always #5 clk = ~clk;

  // Receiving shift register standing in for the SIC end of the link.
  always @(posedge clk) sic_q <= {sic_q[W-2:0], p};

  // Reference model: a queue of bits still to appear on the line.
  typedef struct packed { logic b; logic f; logic dn; } lbit_t;
  lbit_t mq[$];

  typedef struct packed {
    logic v; logic [W-1:0] w;
    logic ep; logic ef; logic eb; logic ed; logic er;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
  endtask

  // One clock of traffic on the main DUT, checked against the model.
  task automatic step(input logic v, input logic [W-1:0] w);
    logic  acc;
    lbit_t e;
    in_valid = v;
    d        = w;
    acc      = v && (mq.size() < W);
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        e.b  = w[W-1-i];
        e.f  = (i == 0);
        e.dn = (i == W - 1);
        mq.push_back(e);
      end
    end
    #1;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      chk("p", p, e.b);
      chk("frame", frame, e.f);
      chk("busy", busy, 1);
      chk("done", done, e.dn);
    end else begin
      chk("p_idle", p, 0);
      chk("frame_idle", frame, 0);
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
    end
    chk("in_ready", in_ready, (mq.size() < W) ? 1 : 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_p6", p6, 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Backpressure: 1011, 0110, 1111 offered continuously.
    tbl[0]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();

    // Test 1: single word 1011 with one cycle of in_valid.
    begin
      logic [3:0] ep;
      logic [3:0] ef;
      logic [3:0] ed;
      ep = 4'b1011; ef = 4'b1000; ed = 4'b0001;
      in_valid = 1'b1; d = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        in_valid = 1'b0; d = 4'b0000;
        chk("t1_p", p, ep[3-i]);
        chk("t1_frame", frame, ef[3-i]);
        chk("t1_done", done, ed[3-i]);
        chk("t1_busy", busy, 1);
      end
      @(posedge clk); #1;
      chk("t1_p_after", p, 0);
      chk("t1_busy_after", busy, 0);
    end

    // Test 2: back-to-back words through the model.
    do_reset();
    step(1'b1, 4'b1011);
    step(1'b1, 4'b0110);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);

    // Test 3: backpressure table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v;
      d        = tbl[i].w;
      @(posedge clk); #1;
      chk($sformatf("t3_p[%0d]", i), p, tbl[i].ep);
      chk($sformatf("t3_frame[%0d]", i), frame, tbl[i].ef);
      chk($sformatf("t3_busy[%0d]", i), busy, tbl[i].eb);
      chk($sformatf("t3_done[%0d]", i), done, tbl[i].ed);
      chk($sformatf("t3_ready[%0d]", i), in_ready, tbl[i].er);
    end

    // Test 4: loopback into a receiving shift register.
    do_reset();
    step(1'b1, 4'b1001);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    chk("t4_sic", sic_q, 4'b1001);

    // Test 5: reset during bit 2 of 1011 with a word held.
    do_reset();
    step(1'b1, 4'b1011);
    step(1'b1, 4'b0110);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_p", p, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", in_ready, 1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);

    // Test 6: LSB first, idle level high.
    begin
      logic [3:0] ep6;
      ep6 = 4'b1011;
      #1;
      chk("t6_idle_before", p6, 1);
      v6 = 1'b1; d6 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        v6 = 1'b0; d6 = 4'b0000;
        chk("t6_p", p6, ep6[i]);
        chk("t6_busy", busy6, 1);
      end
      @(posedge clk); #1;
      chk("t6_p_idle", p6, 1);
      chk("t6_busy_idle", busy6, 0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, W'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
